// File: rtl/nrf_spi_responder.sv
// nRF24L01-style SPI mode-0 target: R_REGISTER / W_REGISTER / NOP decode
// over an 8-entry register file, with write notifications to fabric logic.
module nrf_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CONFIG_RST  = 8'h08,
    parameter logic [7:0]  STATUS_RST  = 8'h0E
) (
    input  logic       clk_10,
    input  logic       rst,
    input  logic       sck,
    input  logic       csn,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       busy,
    output logic       cmd_stb,
    output logic [7:0] cmd_byte,
    output logic       wr_stb,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam int unsigned NREGS = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 5;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_IGNORE} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [SYNC_STAGES-1:0]     r_sck_sync;
    logic [SYNC_STAGES-1:0]     r_csn_sync;
    logic [SYNC_STAGES-1:0]     r_mosi_sync;
    logic                       r_sck_d;
    logic                       r_csn_d;
    logic [NREGS-1:0][DW-1:0]   r_regs;
    logic [6:0]                 r_rx;
    logic [DW-1:0]              r_tx;
    logic [2:0]                 r_bit_cnt;
    logic                       r_miso;
    logic                       r_miso_oe;
    logic                       r_busy;
    logic                       r_cmd_stb;
    logic [DW-1:0]              r_cmd_byte;
    logic                       r_wr_stb;
    logic [AW-1:0]              r_wr_addr;
    logic [DW-1:0]              r_wr_data;

    logic          w_sck;
    logic          w_csn;
    logic          w_mosi;
    logic          w_sck_rise;
    logic          w_sck_fall;
    logic          w_csn_fall;
    logic          w_csn_rise;
    logic          w_byte_done;
    logic          w_wr_en;
    logic [DW-1:0] w_rx_byte;
    logic [DW-1:0] w_rd_data;

    // Pin synchronisers and edge-delay flops; left unreset so they keep
    // tracking the pins during reset and no phantom edge appears at release.
    always_ff @(posedge clk_10) begin
        r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
        r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], csn};
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
        r_csn_d     <= r_csn_sync[SYNC_STAGES-1];
    end

    assign w_sck       = r_sck_sync[SYNC_STAGES-1];
    assign w_csn       = r_csn_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise  = w_sck & ~r_sck_d;
    assign w_sck_fall  = ~w_sck & r_sck_d;
    assign w_csn_fall  = ~w_csn & r_csn_d;
    assign w_csn_rise  = w_csn & ~r_csn_d;
    assign w_rx_byte   = {r_rx, w_mosi};
    // csn rise beats a simultaneous 8th sck rise
    assign w_byte_done = (r_state != S_IDLE) && w_sck_rise && (r_bit_cnt == 3'd7) && !w_csn_rise;
    assign w_wr_en     = w_byte_done && (r_state == S_DATA) && (r_cmd_byte[7:5] == 3'b001);
    assign w_rd_data   = (w_rx_byte[4:3] == 2'b00) ? r_regs[w_rx_byte[2:0]] : 8'h00;

    // State register
    always_ff @(posedge clk_10) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_csn_fall) w_state_nxt = S_CMD;
            S_CMD: begin
                if (w_csn_rise)       w_state_nxt = S_IDLE;
                else if (w_byte_done) w_state_nxt = (w_rx_byte[7:6] == 2'b00) ? S_DATA : S_IGNORE;
            end
            S_DATA: begin
                if (w_csn_rise)       w_state_nxt = S_IDLE;
                else if (w_byte_done) w_state_nxt = S_IGNORE;
            end
            S_IGNORE: if (w_csn_rise) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // Register file; STATUS bits 6:4 are write-1-to-clear, addresses above 7 drop the data
    always_ff @(posedge clk_10) begin
        if (!rst) begin
            r_regs    <= '0;
            r_regs[0] <= CONFIG_RST;
            r_regs[7] <= STATUS_RST;
        end else if (w_wr_en) begin
            if (r_cmd_byte[4:0] == 5'd7)     r_regs[7] <= r_regs[7] & ~(w_rx_byte & 8'h70);
            else if (r_cmd_byte[4:0] < 5'd7) r_regs[r_cmd_byte[2:0]] <= w_rx_byte;
        end
    end

    // Shift datapath and registered outputs; r_tx holds the bits still to be driven
    always_ff @(posedge clk_10) begin
        if (!rst) begin
            r_rx       <= '0;
            r_tx       <= '0;
            r_bit_cnt  <= '0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_cmd_stb  <= 1'b0;
            r_cmd_byte <= 8'hFF;
            r_wr_stb   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_cmd_stb <= 1'b0;
            r_wr_stb  <= 1'b0;
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
                if (w_csn_fall) begin
                    r_busy    <= 1'b1;
                    r_miso_oe <= 1'b1;
                    r_miso    <= r_regs[7][7];
                    r_tx      <= {r_regs[7][6:0], 1'b0};
                end
            end else if (w_csn_rise) begin
                r_busy    <= 1'b0;
                r_miso_oe <= 1'b0;
                r_miso    <= 1'b0;
                r_tx      <= '0;
            end else if (w_sck_rise) begin
                r_rx      <= w_rx_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_byte_done) begin
                    if (r_state == S_CMD) begin
                        r_cmd_stb  <= 1'b1;
                        r_cmd_byte <= w_rx_byte;
                        if (w_rx_byte[7:5] == 3'b000) begin
                            r_tx <= w_rd_data;
                        end else if (w_rx_byte[7:5] != 3'b001) begin
                            r_tx   <= '0;
                            r_miso <= 1'b0;
                        end
                    end else begin
                        if (w_wr_en) begin
                            r_wr_stb  <= 1'b1;
                            r_wr_addr <= r_cmd_byte[4:0];
                            r_wr_data <= w_rx_byte;
                        end
                        r_tx   <= '0;
                        r_miso <= 1'b0;
                    end
                end
            end else if (w_sck_fall) begin
                if (r_state == S_IGNORE) begin
                    r_miso <= 1'b0;
                end else begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end
            end
        end
    end

    assign miso     = r_miso;
    assign miso_oe  = r_miso_oe;
    assign busy     = r_busy;
    assign cmd_stb  = r_cmd_stb;
    assign cmd_byte = r_cmd_byte;
    assign wr_stb   = r_wr_stb;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_nrf_spi_responder.sv
// Directed bench for nrf_spi_responder: a bench-side SPI controller at 1 MHz,
// a register-file model of the nRF command set, and a per-cycle output monitor.
`timescale 1ns/1ps
module tb_nrf_spi_responder;

    localparam int H = 500;   // sck half period (1 MHz sck on a 10 MHz clk)

    logic       clk_10 = 1'b0;
    logic       rst    = 1'b0;
    logic       sck    = 1'b0;
    logic       csn    = 1'b1;
    logic       mosi   = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic       busy;
    logic       cmd_stb;
    logic [7:0] cmd_byte;
    logic       wr_stb;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;

    int n_vec = 0;
    int n_err = 0;
    int n_cmd = 0;
    int n_wr  = 0;

    logic [7:0] m_regs [8];
    logic [7:0] g_mosi [8];
    logic [7:0] g_miso [8];

    always #50 clk_10 = ~clk_10;

    nrf_spi_responder dut (
        .clk_10   (clk_10),
        .rst      (rst),
        .sck      (sck),
        .csn      (csn),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .busy     (busy),
        .cmd_stb  (cmd_stb),
        .cmd_byte (cmd_byte),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle monitor: strobe counting and invariants on the pin outputs
    always @(negedge clk_10) begin
        if (cmd_stb) n_cmd++;
        if (wr_stb)  n_wr++;
        chk("stb_overlap", 32'(cmd_stb & wr_stb), 32'd0);
        chk("oe_vs_busy", 32'(miso_oe), 32'(busy));
        if (!miso_oe) chk("miso_when_deselected", 32'(miso), 32'd0);
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[3'(i)] = 8'h00;
        m_regs[0] = 8'h08;
        m_regs[7] = 8'h0E;
    endtask

    // What the controller must see on miso for byte idx of a transaction
    function automatic logic [7:0] exp_miso(input logic [7:0] cmd, input int idx);
        if (idx == 0) return m_regs[7];
        if (idx == 1 && cmd[7:5] == 3'b000) return (cmd[4:0] <= 5'd7) ? m_regs[cmd[2:0]] : 8'h00;
        return 8'h00;
    endfunction

    // Mode-0 controller: mosi changes while sck low, miso sampled just before the rise
    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[3'(7 - i)];
            #(H);
            mi  = {mi[6:0], miso};
            sck = 1'b1;
            #(H);
            sck = 1'b0;
        end
    endtask

    // nb full bytes from g_mosi, then tail extra bits, then deselect; checks against the model
    task automatic run_txn(input int nb, input int tail);
        logic [7:0] exp_b [8];
        logic [7:0] cmd;
        logic [7:0] dummy;
        int         c0;
        int         w0;
        bit         exp_wr;
        cmd = g_mosi[0];
        for (int i = 0; i < nb; i++) exp_b[3'(i)] = exp_miso(cmd, i);
        exp_wr = (nb >= 2) && (cmd[7:5] == 3'b001);
        c0 = n_cmd;
        w0 = n_wr;
        csn = 1'b0;
        #(H);
        chk("busy_after_select", 32'(busy), 32'd1);
        for (int i = 0; i < nb; i++) spi_bits(g_mosi[3'(i)], 8, g_miso[3'(i)]);
        if (tail > 0) spi_bits(g_mosi[3'(nb)], tail, dummy);
        #(H);
        csn = 1'b1;
        // csn seen after two sync stages, busy drops on the following edge
        #160;
        chk("busy_before_drop", 32'(busy), 32'd1);
        #100;
        chk("busy_dropped", 32'(busy), 32'd0);
        #740;
        for (int i = 0; i < nb; i++) chk("miso_byte", 32'(g_miso[3'(i)]), 32'(exp_b[3'(i)]));
        chk("cmd_stb_count", 32'(n_cmd - c0), 32'((nb >= 1) ? 1 : 0));
        if (nb >= 1) chk("cmd_byte", 32'(cmd_byte), 32'(cmd));
        chk("wr_stb_count", 32'(n_wr - w0), 32'(exp_wr));
        if (exp_wr) begin
            chk("wr_addr", 32'(wr_addr), 32'(cmd[4:0]));
            chk("wr_data", 32'(wr_data), 32'(g_mosi[1]));
            if (cmd[4:0] < 5'd7)       m_regs[cmd[2:0]] = g_mosi[1];
            else if (cmd[4:0] == 5'd7) m_regs[7] = m_regs[7] & ~(g_mosi[1] & 8'h70);
        end
    endtask

    task automatic set2(input logic [7:0] a, input logic [7:0] b);
        g_mosi[0] = a;
        g_mosi[1] = b;
    endtask

    initial begin
        logic [7:0] dummy;
        int         c0;
        model_reset();
        for (int i = 0; i < 8; i++) g_mosi[3'(i)] = 8'hFF;
        #20;
        #1000;
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_stb", 32'(cmd_stb), 32'd0);
        chk("rst_wr_stb", 32'(wr_stb), 32'd0);
        chk("rst_cmd_byte", 32'(cmd_byte), 32'hFF);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b1;
        #1000;

        // Reads of CONFIG and STATUS reset values
        set2(8'h00, 8'hFF); run_txn(2, 0);
        chk("lit_status_byte0", 32'(g_miso[0]), 32'h0E);
        chk("lit_config_read", 32'(g_miso[1]), 32'h08);
        set2(8'h07, 8'hFF); run_txn(2, 0);
        chk("lit_status_read", 32'(g_miso[1]), 32'h0E);

        // Write then read back
        set2(8'h25, 8'h5A); run_txn(2, 0);
        chk("lit_wr_addr", 32'(wr_addr), 32'd5);
        chk("lit_wr_data", 32'(wr_data), 32'h5A);
        set2(8'h05, 8'hFF); run_txn(2, 0);
        chk("lit_read_back", 32'(g_miso[1]), 32'h5A);

        // STATUS: only bits 6:4 clear, nothing sets
        set2(8'h27, 8'hF1); run_txn(2, 0);
        set2(8'h07, 8'hFF); run_txn(2, 0);
        chk("lit_status_after_w1c", 32'(g_miso[1]), 32'h0E);

        // Write aborted after 4 data bits
        set2(8'h23, 8'hAB); run_txn(1, 4);
        set2(8'h03, 8'hFF); run_txn(2, 0);
        chk("lit_aborted_write", 32'(g_miso[1]), 32'h00);

        // Out-of-range address: strobe fires, storage untouched, reads 0
        set2(8'h22, 8'h44); run_txn(2, 0);
        set2(8'h2A, 8'h33); run_txn(2, 0);
        set2(8'h0A, 8'hFF); run_txn(2, 0);
        set2(8'h02, 8'hFF); run_txn(2, 0);
        chk("lit_no_alias", 32'(g_miso[1]), 32'h44);

        // CONFIG write, then a read with trailing bytes
        set2(8'h20, 8'h7B); run_txn(2, 0);
        set2(8'h00, 8'h11); g_mosi[2] = 8'h22; g_mosi[3] = 8'h33; run_txn(4, 0);

        // NOP with three extra bytes, and an unsupported command
        set2(8'hFF, 8'hA5); g_mosi[2] = 8'h5A; g_mosi[3] = 8'hC3; run_txn(4, 0);
        set2(8'h61, 8'h99); run_txn(2, 0);

        // sck toggling while deselected must not disturb bit alignment
        set2(8'h26, 8'hC3); run_txn(2, 0);
        c0 = n_cmd;
        for (int i = 0; i < 8; i++) begin
            sck = 1'b1; #(H); sck = 1'b0; #(H);
        end
        chk("sck_while_deselected", 32'(n_cmd - c0), 32'd0);
        set2(8'h06, 8'hFF); run_txn(2, 0);
        chk("lit_read_after_idle_sck", 32'(g_miso[1]), 32'hC3);

        // Reset mid-byte
        c0 = n_cmd;
        csn = 1'b0;
        #(H);
        spi_bits(8'h00, 3, dummy);
        rst = 1'b0;
        #100;
        chk("midrst_miso", 32'(miso), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        #100;
        rst = 1'b1;
        model_reset();
        spi_bits(8'hFF, 5, dummy);
        #(H);
        csn = 1'b1;
        #(2 * H);
        chk("midrst_no_cmd_stb", 32'(n_cmd - c0), 32'd0);
        chk("midrst_cmd_byte", 32'(cmd_byte), 32'hFF);
        set2(8'h05, 8'hFF); run_txn(2, 0);
        chk("lit_reg5_after_rst", 32'(g_miso[1]), 32'h00);
        set2(8'h00, 8'hFF); run_txn(2, 0);
        chk("lit_config_after_rst", 32'(g_miso[1]), 32'h08);

        #1000;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
